// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS hex digits with frame-aligned
// value updates, per-digit blanking and leading-zero suppression.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic [6:0]              seg,
    output logic                    frame_done
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         staged_q, staged_d, shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  fdone_q;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic [6:0]            seg_q, seg_d;
    logic                  tick, boundary;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [3:0]            nib;
    logic                  blank;
    logic [NUM_DIGITS-1:0] dig_on;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: hex_decode = 7'b0111111;
            4'h1: hex_decode = 7'b0000110;
            4'h2: hex_decode = 7'b1011011;
            4'h3: hex_decode = 7'b1001111;
            4'h4: hex_decode = 7'b1100110;
            4'h5: hex_decode = 7'b1101101;
            4'h6: hex_decode = 7'b1111101;
            4'h7: hex_decode = 7'b0000111;
            4'h8: hex_decode = 7'b1111111;
            4'h9: hex_decode = 7'b1101111;
            4'hA: hex_decode = 7'b1110111;
            4'hB: hex_decode = 7'b1111100;
            4'hC: hex_decode = 7'b0111001;
            4'hD: hex_decode = 7'b1011110;
            4'hE: hex_decode = 7'b1111001;
            default: hex_decode = 7'b1110001;
        endcase
    endfunction

    assign tick     = (presc_q == PRE_MAX);
    assign boundary = tick && (idx_q == IDX_MAX);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        staged_d  = staged_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        if (load) begin
            staged_d  = value;
            pending_d = 1'b1;
        end
        // A load landing on the boundary bypasses staging so it shows next frame.
        if (boundary) begin
            if (load) begin
                shadow_d  = value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                shadow_d  = staged_q;
                pending_d = 1'b0;
            end
        end
    end

    // zero_from[i]: nibbles i..NUM_DIGITS-1 of the shown value are all zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (shadow_q[4*i +: 4] == 4'h0);
            zero_from[i] = acc;
        end
    end

    always_comb begin
        nib    = 4'h0;
        blank  = 1'b0;
        dig_on = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib       = shadow_q[4*i +: 4];
                blank     = blank_mask[i] || (lz_blank && (i > 0) && zero_from[i]);
                dig_on[i] = 1'b1;
            end
        end
        if (blank) dig_on = '0;
        dig_d = {NUM_DIGITS{ACTIVE_LOW}} ^ dig_on;
        seg_d = {7{ACTIVE_LOW}} ^ (blank ? 7'h00 : hex_decode(nib));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            staged_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            fdone_q   <= 1'b0;
            dig_q     <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q     <= {7{ACTIVE_LOW}};
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            staged_q  <= staged_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            fdone_q   <= boundary;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
        end
    end

    assign dig        = dig_q;
    assign seg        = seg_q;
    assign frame_done = fdone_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Two driver configurations (4 digits active-low, 6 digits active-high) share one stimulus
// stream and are compared each cycle against a cycle-count based reference model.
module tb_seven_seg_scan_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, lz;
    logic [31:0] v;
    logic [7:0]  bm;
    logic [3:0]  dig0;
    logic [5:0]  dig1;
    logic [6:0]  seg0, seg1;
    logic        fd0, fd1;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .value(v[15:0]), .load(load), .blank_mask(bm[3:0]),
        .lz_blank(lz), .dig(dig0), .seg(seg0), .frame_done(fd0));

    seven_seg_scan_driver #(.NUM_DIGITS(6), .REFRESH_DIV(3), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .value(v[23:0]), .load(load), .blank_mask(bm[5:0]),
        .lz_blank(lz), .dig(dig1), .seg(seg1), .frame_done(fd1));

    int n_chk = 0;
    int n_fail = 0;

    int          ND[2] = '{4, 6};
    int          RD[2] = '{4, 3};
    bit          AL[2] = '{1'b1, 1'b0};
    logic [6:0]  SEG_T[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: cycles since reset, shown/staged values, pending flag.
    int          nc[2];
    logic [31:0] sh[2], st[2];
    bit          pend[2];
    logic [31:0] e_dig[2];
    logic [6:0]  e_seg[2];
    logic        e_fd[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input int k);
        int R, N, idx;
        bit bnd, blk;
        logic [31:0] dmask, vmask, on, shifted;
        logic [6:0] son;
        R = RD[k];
        N = ND[k];
        dmask = (32'd1 << N) - 1;
        vmask = (N == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * N)) - 1);
        if (rst) begin
            nc[k] = 0; sh[k] = 0; st[k] = 0; pend[k] = 0;
            e_dig[k] = AL[k] ? dmask : 32'd0;
            e_seg[k] = AL[k] ? 7'h7F : 7'h00;
            e_fd[k] = 1'b0;
            return;
        end
        idx = (nc[k] / R) % N;
        bnd = (nc[k] % R == R - 1) && (idx == N - 1);
        shifted = sh[k] >> (4 * idx);
        blk = bm[idx] || (lz && idx > 0 && shifted == 0);
        on  = blk ? 32'd0 : (32'd1 << idx);
        son = blk ? 7'h00 : SEG_T[shifted[3:0]];
        e_dig[k] = AL[k] ? (~on & dmask) : on;
        e_seg[k] = AL[k] ? ~son : son;
        e_fd[k]  = bnd;
        if (bnd && load) begin
            sh[k] = v & vmask; pend[k] = 0;
        end else if (bnd && pend[k]) begin
            sh[k] = st[k]; pend[k] = 0;
        end
        if (load) begin
            st[k] = v & vmask;
            if (!bnd) pend[k] = 1;
        end
        nc[k]++;
    endtask

    task automatic step();
        model(0);
        model(1);
        @(posedge clk);
        #1;
        chk("dig0", {28'd0, dig0}, e_dig[0]);
        chk("seg0", {25'd0, seg0}, {25'd0, e_seg[0]});
        chk("fd0",  {31'd0, fd0},  {31'd0, e_fd[0]});
        chk("dig1", {26'd0, dig1}, e_dig[1]);
        chk("seg1", {25'd0, seg1}, {25'd0, e_seg[1]});
        chk("fd1",  {31'd0, fd1},  {31'd0, e_fd[1]});
    endtask

    task automatic run(input int c);
        repeat (c) step();
    endtask

    task automatic ld(input logic [31:0] val);
        v = val;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; lz = 1'b0; bm = 8'h00; v = 32'h0;
        run(5);
        rst = 1'b0;
        run(40);
        // mid-frame load of 12AF
        run(5);
        ld(32'h0000_12AF);
        run(40);
        // load in the exact boundary cycle of the 4-digit instance
        while (nc[0] % 16 != 15) step();
        ld(32'h0000_0008);
        run(20);
        // leading-zero suppression
        lz = 1'b1;
        ld(32'h0000_0030);
        run(40);
        ld(32'h0000_0000);
        run(40);
        lz = 1'b0;
        // per-digit blanking
        bm = 8'h05;
        ld(32'h0088_8888);
        run(40);
        bm = 8'h00;
        // reset mid-frame discards a pending load
        while (nc[0] % 16 != 2) step();
        ld(32'h00FF_FFFF);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(40);
        // randomized traffic
        repeat (2000) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 7) == 0);
            v    = $urandom;
            if ($urandom_range(0, 31) == 0) bm = 8'($urandom);
            if ($urandom_range(0, 31) == 0) lz = 1'($urandom);
            step();
        end
        rst = 1'b0;
        load = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
